spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Byte-oriented SPI mode-0 master: CPOL=0, CPHA=0, MSB first, active-low SSEL.
- Drives SCK/MOSI/SSEL toward the FPGA-side SPI slave logic or off-chip SPI peripherals, and captures MISO.
- Accepts bytes through a valid/ready interface and returns each received byte as a one-cycle pulse.
- Multi-byte messages keep SSEL low until the byte flagged `tx_last` completes.

Parameters:
- CLK_DIV, 8: `clk` cycles per SCK half-period. Legal range ≥2; values <2 are illegal (elaboration error).
- CS_SETUP, 2: `clk` cycles SSEL is low before the first SCK rising edge of a message. Legal range ≥1.
- CS_HOLD, 2: `clk` cycles SSEL stays low after the last SCK falling edge of a message. Legal range ≥1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- tx_valid  input  1  byte offered
- tx_data  input  8  byte to send
- tx_last  input  1  offered byte ends the message
- tx_ready  output  1  master can accept a byte
- rx_valid  output  1  one-cycle pulse: rx_data holds a received byte
- rx_data  output  8  received byte
- busy  output  1  SSEL asserted or transfer pending
- SCK  output  1  SPI clock
- MOSI  output  1  master out
- SSEL  output  1  slave select, active low
- MISO  input  1  master in; double-flop synchronised internally

Behaviour:
- Reset (`rst_n`=0 at a `clk` rising edge), including mid-transfer:
  - state=IDLE, SSEL=1, SCK=0, MOSI=0, tx_ready=0 in the reset cycle, rx_valid=0, rx_data=0, busy=0.
  - Any in-flight byte is discarded; no rx_valid is produced for it.
- All outputs are registered.
- States: IDLE, SETUP, LOW, HIGH, NEXT, HOLD.
- IDLE:
  - tx_ready=1, SSEL=1, SCK=0.
  - On tx_valid&tx_ready: latch tx_data into the shift register and latch tx_last; next cycle SSEL=0, MOSI=tx_data[7], busy=1, go to SETUP.
- SETUP:
  - Hold for CS_SETUP cycles, then go to LOW.
- LOW:
  - SCK=0 for CLK_DIV cycles; MOSI is stable.
  - At the end, SCK←1 and go to HIGH.
- HIGH:
  - SCK=1 for CLK_DIV cycles.
  - The synchronised MISO is sampled in the last HIGH cycle, so slave turnaround latency up to CLK_DIV-1 cycles is tolerated.
  - At the end, SCK←0 and bitcnt increments.
  - If bitcnt<7: MOSI←next bit, go to LOW.
  - If bitcnt=7: in the same cycle SCK falls, rx_data←assembled byte and rx_valid=1 for exactly one cycle. Then go to HOLD if the latched last=1, else NEXT.
- Bit timing: each byte takes 16×CLK_DIV cycles of SCK activity. A single-byte message with defaults has SSEL low for 2+128+2=132 cycles.
- NEXT:
  - tx_ready=1, SSEL held low, SCK held low; waits indefinitely (no timeout).
  - On accept: load the byte, MOSI←tx_data[7], go directly to LOW. No re-setup.
- HOLD:
  - Hold CS_HOLD cycles, then SSEL←1 and go to IDLE.
  - tx_ready stays 0 for that first IDLE cycle, guaranteeing SSEL is high for ≥1 cycle between messages.
- tx_ready=0 in SETUP, LOW, HIGH and HOLD; tx_valid is ignored there.
- tx_data/tx_last are sampled only on the accept cycle.
- busy=1 from the cycle after accept until SSEL returns high.
- bitcnt is 3 bits and wraps 7→0 at byte end.

Optional Feature:
- Macro SPI_MASTER_LOOPBACK_EN.
- Defined: adds input port `loopback` (1 bit). While high, the HIGH-phase sample takes the internal MOSI register instead of synchronised MISO, so rx_data equals tx_data. Pins behave unchanged.
- Undefined: no `loopback` port; sampling always uses MISO.

Test Plan:
- Reset, send 0xA5 with tx_last=1, MISO tied 1 → MOSI at the 8 SCK rising edges is 1,0,1,0,0,1,0,1; exactly 8 SCK pulses; SSEL low for 132 cycles; a single rx_valid carries rx_data=0xFF; busy=0 afterwards.
- MISO model shifts 0x3C, updating 3 `clk` cycles after each SCK falling edge → rx_data=0x3C.
- 3-byte burst 0x11,0x22,0x33 (tx_last on 0x33), tx_valid withheld 20 cycles before byte 2 → SSEL continuously low; SCK low and tx_ready=1 during the gap; three rx_valid pulses; then SSEL rises after CS_HOLD.
- Back-to-back messages with tx_valid held high → SSEL high for ≥1 cycle between messages; second message again has CS_SETUP cycles before the first SCK edge.
- Assert rst_n=0 mid-bit-4 of a byte → next cycle SSEL=1, SCK=0, MOSI=0, no rx_valid; a following fresh 0x5A transfer is correct.
- With SPI_MASTER_LOOPBACK_EN and loopback=1, MISO=0 → sending 0xC3 returns rx_data=0xC3; with loopback=0 it returns 0x00.

Source files
------------

// File: rtl/spi_master.sv
`timescale 1ns/1ps
// spi_master: byte-oriented SPI mode-0 master (CPOL=0, CPHA=0, MSB first, active-low SSEL).
// Optional macro SPI_MASTER_LOOPBACK_EN adds a `loopback` input that samples MOSI instead of MISO.
module spi_master #(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       SCK,
  output logic       MOSI,
  output logic       SSEL,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic       loopback,
`endif
  input  logic       MISO
);

  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ?
                           ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                           ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("spi_master: CLK_DIV must be >= 2");
    end
    if (CS_SETUP < 1 || CS_HOLD < 1) begin : g_bad_cs
      $error("spi_master: CS_SETUP and CS_HOLD must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, NEXT, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bitcnt_reg, bitcnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             last_reg, last_next;
  logic [1:0]       miso_sync_reg;
  logic             tx_ready_reg, tx_ready_next;
  logic             rx_valid_reg, rx_valid_next;
  logic [7:0]       rx_data_reg, rx_data_next;
  logic             busy_reg, busy_next;
  logic             sck_reg, sck_next;
  logic             mosi_reg, mosi_next;
  logic             ssel_reg, ssel_next;
  logic             accept, bit_end, sample;

  assign accept  = tx_valid && tx_ready_reg;
  assign bit_end = (state_reg == HIGH) && (cnt_reg == DIV_LAST);
`ifdef SPI_MASTER_LOOPBACK_EN
  assign sample = loopback ? mosi_reg : miso_sync_reg[1];
`else
  assign sample = miso_sync_reg[1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bitcnt_reg    <= '0;
      shift_reg     <= '0;
      last_reg      <= 1'b0;
      miso_sync_reg <= '0;
      tx_ready_reg  <= 1'b0;
      rx_valid_reg  <= 1'b0;
      rx_data_reg   <= '0;
      busy_reg      <= 1'b0;
      sck_reg       <= 1'b0;
      mosi_reg      <= 1'b0;
      ssel_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bitcnt_reg    <= bitcnt_next;
      shift_reg     <= shift_next;
      last_reg      <= last_next;
      miso_sync_reg <= {miso_sync_reg[0], MISO};
      tx_ready_reg  <= tx_ready_next;
      rx_valid_reg  <= rx_valid_next;
      rx_data_reg   <= rx_data_next;
      busy_reg      <= busy_next;
      sck_reg       <= sck_next;
      mosi_reg      <= mosi_next;
      ssel_reg      <= ssel_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   if (cnt_reg == SETUP_LAST) state_next = LOW;
      LOW:     if (cnt_reg == DIV_LAST) state_next = HIGH;
      HIGH:    if (bit_end) begin
                 if (bitcnt_reg != 3'd7) state_next = LOW;
                 else                    state_next = last_reg ? HOLD : NEXT;
               end
      NEXT:    if (accept) state_next = LOW;
      HOLD:    if (cnt_reg == HOLD_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output registers are loaded from the upcoming state so every pin changes on the transition edge.
  always_comb begin
    cnt_next      = '0;
    bitcnt_next   = bitcnt_reg;
    shift_next    = shift_reg;
    last_next     = last_reg;
    mosi_next     = mosi_reg;
    rx_valid_next = 1'b0;
    rx_data_next  = rx_data_reg;
    if ((state_next == state_reg) && (state_reg inside {SETUP, LOW, HIGH, HOLD}))
      cnt_next = cnt_reg + CNT_W'(1);
    if (accept) begin
      shift_next  = tx_data;
      last_next   = tx_last;
      mosi_next   = tx_data[7];
      bitcnt_next = '0;
    end
    if (bit_end) begin
      bitcnt_next = bitcnt_reg + 3'd1;
      shift_next  = {shift_reg[6:0], sample};
      if (bitcnt_reg == 3'd7) begin
        rx_valid_next = 1'b1;
        rx_data_next  = {shift_reg[6:0], sample};
      end else begin
        mosi_next = shift_reg[6];
      end
    end
    // First IDLE cycle after HOLD keeps tx_ready low so SSEL has a visible high gap.
    tx_ready_next = ((state_next == IDLE) && (state_reg == IDLE)) || (state_next == NEXT);
    ssel_next     = (state_next == IDLE);
    sck_next      = (state_next == HIGH);
    busy_next     = (state_next != IDLE);
  end

  assign tx_ready = tx_ready_reg;
  assign rx_valid = rx_valid_reg;
  assign rx_data  = rx_data_reg;
  assign busy     = busy_reg;
  assign SCK      = sck_reg;
  assign MOSI     = mosi_reg;
  assign SSEL     = ssel_reg;

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
// tb_spi_master: table-driven single-byte vectors plus burst, back-to-back, reset and loopback sequences.
module tb_spi_master;
  localparam int CLK_DIV  = 8;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int MSG_LOW  = CS_SETUP + 16 * CLK_DIV + CS_HOLD;  // 132
  localparam int LEAD     = CS_SETUP + CLK_DIV;                 // SSEL fall to first SCK rise

  logic       clk = 1'b0;
  logic       rst_n, tx_valid, tx_last, tx_ready, rx_valid, busy, SCK, MOSI, SSEL, MISO;
  logic [7:0] tx_data, rx_data;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic       loopback;
`endif

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .SCK(SCK), .MOSI(MOSI), .SSEL(SSEL),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(loopback),
`endif
    .MISO(MISO)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Slave model: mode 0 shifts slave_bytes out MSB first, updating 3 cycles after each SCK fall.
  logic       slave_mode = 1'b0;
  logic       miso_const = 1'b0;
  logic [7:0] slave_bytes [4];
  logic [7:0] s_sh = 8'h00;
  int         s_idx = 0, s_bitn = 0, s_dly = 0;
  logic       s_prev_ssel = 1'b1, s_prev_sck = 1'b0;

  always @(negedge clk) begin
    if (s_prev_ssel && !SSEL) begin
      s_idx = 0; s_sh = slave_bytes[0]; s_bitn = 0; s_dly = 0;
    end else if (s_prev_sck && !SCK) begin
      s_dly = 3;
    end else if (s_dly > 0) begin
      s_dly--;
      if (s_dly == 0) begin
        s_bitn++;
        if (s_bitn == 8) begin
          s_bitn = 0; s_idx++;
          s_sh = (s_idx < 4) ? slave_bytes[s_idx] : 8'h00;
        end else begin
          s_sh = s_sh << 1;
        end
      end
    end
    MISO = slave_mode ? s_sh[7] : miso_const;
    s_prev_ssel = SSEL;
    s_prev_sck  = SCK;
  end

  // Pin monitor, sampled on the falling clk edge.
  logic       stats_clr = 1'b0;
  int         sck_rises, ssel_low_cnt, ssel_rises, rx_cnt, setup_lead, hold_tail, gap_cnt, last_gap, mosi_bitn;
  logic [7:0] mosi_sh;
  logic       m_prev_sck, m_prev_ssel, seen_sck;
  logic [7:0] mosi_q [$];
  logic [7:0] rx_q [$];

  always @(negedge clk) begin
    if (stats_clr) begin
      sck_rises = 0; ssel_low_cnt = 0; ssel_rises = 0; rx_cnt = 0; setup_lead = 0;
      hold_tail = 0; gap_cnt = 0; last_gap = 0; mosi_bitn = 0; mosi_sh = 8'h00; seen_sck = 1'b0;
      mosi_q.delete(); rx_q.delete();
    end else begin
      if (!SSEL) ssel_low_cnt++;
      if (m_prev_ssel && !SSEL) begin setup_lead = 0; seen_sck = 1'b0; last_gap = gap_cnt; end
      if (!m_prev_ssel && SSEL) begin ssel_rises++; gap_cnt = 0; end
      if (SSEL) gap_cnt++;
      if (!SSEL && !SCK && !seen_sck) setup_lead++;
      if (SCK && !m_prev_sck) begin
        sck_rises++; seen_sck = 1'b1;
        mosi_sh = {mosi_sh[6:0], MOSI}; mosi_bitn++;
        if (mosi_bitn == 8) begin mosi_q.push_back(mosi_sh); mosi_bitn = 0; end
      end
      if (!SCK && m_prev_sck) hold_tail = 0;
      if (!SSEL && !SCK) hold_tail++;
      if (rx_valid) begin rx_cnt++; rx_q.push_back(rx_data); end
    end
    m_prev_sck  = SCK;
    m_prev_ssel = SSEL;
  end

  task automatic clear_stats();
    @(posedge clk); stats_clr = 1'b1;
    @(posedge clk); stats_clr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int w = 0;
    @(negedge clk);
    while (!tx_ready && w < 2000) begin @(negedge clk); w++; end
    if (!tx_ready) check("tx_ready_timeout", 0, 1);
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((busy || !SSEL) && w < 4000) begin @(negedge clk); w++; end
    if (busy || !SSEL) check("idle_timeout", 0, 1);
    repeat (4) @(negedge clk);
  endtask

  function automatic int q_at(input logic [7:0] q [$], input int i);
    return (i < q.size()) ? int'(q[i]) : -1;
  endfunction

  typedef struct {
    logic [7:0] tx;
    logic       smode;
    logic       mconst;
    logic [7:0] sbyte;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs [4];

  initial begin
    int w, acc, viol;
    vecs[0] = '{tx: 8'hA5, smode: 1'b0, mconst: 1'b1, sbyte: 8'h00, exp_rx: 8'hFF};
    vecs[1] = '{tx: 8'h00, smode: 1'b1, mconst: 1'b0, sbyte: 8'h3C, exp_rx: 8'h3C};
    vecs[2] = '{tx: 8'h5A, smode: 1'b0, mconst: 1'b0, sbyte: 8'h00, exp_rx: 8'h00};
    vecs[3] = '{tx: 8'hFF, smode: 1'b1, mconst: 1'b0, sbyte: 8'h81, exp_rx: 8'h81};
    for (int i = 0; i < 4; i++) slave_bytes[i] = 8'h00;

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_pins{SSEL,SCK,MOSI,tx_ready,rx_valid,busy}",
          int'({SSEL, SCK, MOSI, tx_ready, rx_valid, busy}), int'(6'b100000));
    check("reset_rx_data", int'(rx_data), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_tx_ready", int'(tx_ready), 1);

    for (int i = 0; i < 4; i++) begin
      slave_mode = vecs[i].smode; miso_const = vecs[i].mconst; slave_bytes[0] = vecs[i].sbyte;
      clear_stats();
      send_byte(vecs[i].tx, 1'b1);
      wait_idle();
      check("vec_mosi_byte", q_at(mosi_q, 0), int'(vecs[i].tx));
      check("vec_sck_pulses", sck_rises, 8);
      check("vec_ssel_low_cycles", ssel_low_cnt, MSG_LOW);
      check("vec_setup_lead", setup_lead, LEAD);
      check("vec_hold_tail", hold_tail, CS_HOLD);
      check("vec_rx_pulses", rx_cnt, 1);
      check("vec_rx_data", q_at(rx_q, 0), int'(vecs[i].exp_rx));
      check("vec_busy_after", int'(busy), 0);
      $display("vec %0d: tx=%02h rx=%02h sck=%0d ssel_low=%0d", i, vecs[i].tx, rx_data, sck_rises, ssel_low_cnt);
    end

    // Three-byte burst with a 20-cycle gap before byte 2.
    slave_mode = 1'b1;
    slave_bytes[0] = 8'hC1; slave_bytes[1] = 8'h5E; slave_bytes[2] = 8'h07;
    clear_stats();
    send_byte(8'h11, 1'b0);
    w = 0;
    while (rx_cnt < 1 && w < 2000) begin @(negedge clk); w++; end
    check("burst_first_rx", rx_cnt, 1);
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      if (SCK || !tx_ready || SSEL) viol++;
      @(negedge clk);
    end
    check("burst_gap_idle_violations", viol, 0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    wait_idle();
    check("burst_ssel_rises", ssel_rises, 1);
    check("burst_sck_pulses", sck_rises, 24);
    check("burst_rx_pulses", rx_cnt, 3);
    check("burst_rx0", q_at(rx_q, 0), 8'hC1);
    check("burst_rx1", q_at(rx_q, 1), 8'h5E);
    check("burst_rx2", q_at(rx_q, 2), 8'h07);
    check("burst_mosi1", q_at(mosi_q, 1), 8'h22);
    check("burst_mosi2", q_at(mosi_q, 2), 8'h33);
    check("burst_hold_tail", hold_tail, CS_HOLD);
    $display("burst: rx=%0d bytes sck=%0d ssel_rises=%0d", rx_cnt, sck_rises, ssel_rises);

    // Back-to-back messages with tx_valid held high.
    slave_bytes[0] = 8'h6B;
    clear_stats();
    @(negedge clk);
    tx_data = 8'h96; tx_last = 1'b1; tx_valid = 1'b1;
    acc = 0; w = 0;
    while (acc < 2 && w < 4000) begin
      if (tx_ready && tx_valid) acc++;
      if (acc < 2) begin @(negedge clk); w++; end
    end
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
    check("b2b_accepts", acc, 2);
    wait_idle();
    check("b2b_ssel_rises", ssel_rises, 2);
    check("b2b_ssel_high_gap", last_gap, 2);
    check("b2b_second_setup_lead", setup_lead, LEAD);
    check("b2b_sck_pulses", sck_rises, 16);
    check("b2b_rx_pulses", rx_cnt, 2);
    check("b2b_rx1", q_at(rx_q, 1), 8'h6B);
    check("b2b_mosi1", q_at(mosi_q, 1), 8'h96);
    $display("b2b: gap=%0d lead=%0d rx1=%02h", last_gap, setup_lead, rx_data);

    // Reset during bit 4 of 0xF8 (MOSI is 1 there), then a fresh transfer.
    slave_bytes[0] = 8'hE7;
    clear_stats();
    send_byte(8'hF8, 1'b1);
    w = 0;
    while (sck_rises < 5 && w < 2000) begin @(negedge clk); w++; end
    check("rst_reached_bit4", sck_rises, 5);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_pins{SSEL,SCK,MOSI,tx_ready,rx_valid,busy}",
          int'({SSEL, SCK, MOSI, tx_ready, rx_valid, busy}), int'(6'b100000));
    check("rst_mid_rx_data", int'(rx_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("rst_mid_no_rx", rx_cnt, 0);
    check("rst_mid_ssel_idle", int'(SSEL), 1);
    slave_bytes[0] = 8'hA3;
    clear_stats();
    send_byte(8'h5A, 1'b1);
    wait_idle();
    check("post_rst_mosi", q_at(mosi_q, 0), 8'h5A);
    check("post_rst_rx", q_at(rx_q, 0), 8'hA3);
    check("post_rst_sck", sck_rises, 8);
    check("post_rst_ssel_low", ssel_low_cnt, MSG_LOW);
    $display("reset-recovery: tx=5a rx=%02h", rx_data);

`ifdef SPI_MASTER_LOOPBACK_EN
    slave_mode = 1'b0; miso_const = 1'b0;
    loopback = 1'b1;
    clear_stats();
    send_byte(8'hC3, 1'b1);
    wait_idle();
    check("loopback_on_rx", q_at(rx_q, 0), 8'hC3);
    $display("loopback=1: tx=c3 rx=%02h", rx_data);
    loopback = 1'b0;
    clear_stats();
    send_byte(8'hC3, 1'b1);
    wait_idle();
    check("loopback_off_rx", q_at(rx_q, 0), 8'h00);
    $display("loopback=0: tx=c3 rx=%02h", rx_data);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
